// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the PC,
//            issues single-outstanding requests to a handshaked instruction
//            memory, and drives the IF/ID pipeline register. A 1-entry skid
//            buffer absorbs a response that lands while the pipe is frozen.
//            Branch redirects from EX take priority over everything.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            freeze               - hazard stall, IF/ID and PC hold
//            branch_taken/_address- redirect from EX (address bits [1:0] ignored)
//            imem_req/_addr       - request valid / word-aligned address
//            imem_ready           - memory accepts the request this cycle
//            imem_rvalid/_rdata   - single-cycle response
//            if_id_pc             - fetched PC + 4
//            if_id_instruction    - fetched instruction, zero for a bubble
//            if_id_valid          - IF/ID holds a real instruction
//            perf_fetched/_bubbles/_discards - only with FETCH_PERF_CNT_EN
// Options  : FETCH_PERF_CNT_EN adds three saturating 32-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_address,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles,
  output logic [31:0]            perf_discards,
`endif
  output logic                   if_id_valid
);

  localparam logic [PC_WIDTH-1:0] c_RESET_PC = {RESET_PC[PC_WIDTH-1:2], 2'b00};
  localparam logic [PC_WIDTH-1:0] c_PC_STEP  = PC_WIDTH'(4);

  // Skid occupancy is implied by S_HOLD: the buffer is full exactly there.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    w_pc_nxt;
  logic [PC_WIDTH-1:0]    r_inflight_pc;
  logic [PC_WIDTH-1:0]    w_inflight_nxt;
  logic                   r_discard;
  logic                   w_discard_nxt;
  logic [INSTR_WIDTH-1:0] r_skid_instr;
  logic [INSTR_WIDTH-1:0] w_skid_nxt;

  logic [PC_WIDTH-1:0]    r_if_id_pc;
  logic [INSTR_WIDTH-1:0] r_if_id_instr;
  logic                   r_if_id_valid;

  logic                   w_deliver;
  logic [PC_WIDTH-1:0]    w_deliver_pc;
  logic [INSTR_WIDTH-1:0] w_deliver_instr;

  logic [PC_WIDTH-1:0]    w_branch_pc;
  logic [PC_WIDTH-1:0]    w_seq_pc;
  logic                   w_unused_addr_bits;

  assign w_branch_pc        = {branch_address[PC_WIDTH-1:2], 2'b00};
  assign w_seq_pc           = r_inflight_pc + c_PC_STEP;
  assign w_unused_addr_bits = ^branch_address[1:0];

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;

  // --------------------------------------------------------------------------
  // Next-state / datapath decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inflight_nxt  = r_inflight_pc;
    w_discard_nxt   = r_discard;
    w_skid_nxt      = r_skid_instr;
    w_deliver       = 1'b0;
    w_deliver_pc    = r_pc;
    w_deliver_instr = r_skid_instr;

    if (branch_taken) begin
      w_pc_nxt = w_branch_pc;
      unique case (r_state)
        S_REQ: begin
          // A request accepted in the redirect cycle is for the wrong path;
          // wait out its response and throw it away.
          if (imem_ready) begin
            w_inflight_nxt = r_pc;
            w_discard_nxt  = 1'b1;
            w_state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        default: begin
          // Leaving HOLD empties the skid buffer.
          w_state_nxt = S_REQ;
        end
      endcase
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            w_inflight_nxt = r_pc;
            w_state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = S_REQ;
            end else if (!freeze) begin
              w_deliver       = 1'b1;
              w_deliver_pc    = w_seq_pc;
              w_deliver_instr = imem_rdata;
              w_pc_nxt        = w_seq_pc;
              w_state_nxt     = S_REQ;
            end else begin
              w_skid_nxt  = imem_rdata;
              w_pc_nxt    = w_seq_pc;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // r_pc already advanced to inflight_pc + 4 when the skid filled.
          if (!freeze) begin
            w_deliver       = 1'b1;
            w_deliver_pc    = r_pc;
            w_deliver_instr = r_skid_instr;
            w_state_nxt     = S_REQ;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= c_RESET_PC;
      r_inflight_pc <= '0;
      r_discard     <= 1'b0;
      r_skid_instr  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_inflight_pc <= w_inflight_nxt;
      r_discard     <= w_discard_nxt;
      r_skid_instr  <= w_skid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID pipeline register. A bubble keeps the previous pc.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_if_id_valid <= 1'b0;
    end else if (branch_taken || !freeze) begin
      if (w_deliver) begin
        r_if_id_pc    <= w_deliver_pc;
        r_if_id_instr <= w_deliver_instr;
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id_instr <= '0;
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign if_id_pc          = r_if_id_pc;
  assign if_id_instruction = r_if_id_instr;
  assign if_id_valid       = r_if_id_valid;

`ifdef FETCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating event counters
  // --------------------------------------------------------------------------
  logic        w_bubble_load;
  logic        w_drop;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_discards;

  // w_deliver is never set in a redirect cycle, so the two loads are exclusive.
  assign w_bubble_load = branch_taken || (!freeze && !w_deliver);
  assign w_drop        = (r_state == S_WAIT) && imem_rvalid && (r_discard || branch_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched  <= '0;
      r_perf_bubbles  <= '0;
      r_perf_discards <= '0;
    end else begin
      if (w_deliver && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_bubble_load && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
      if (w_drop && (r_perf_discards != 32'hFFFF_FFFF)) begin
        r_perf_discards <= r_perf_discards + 32'd1;
      end
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_bubbles  = r_perf_bubbles;
  assign perf_discards = r_perf_discards;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Randomized scoreboard bench for if_fetch_unit. A memory model
//            answers requests with random latency; a reference model tracks
//            the program stream at the level of "which fetches survive
//            redirects" and queues the instructions expected in IF/ID; a
//            monitor compares every IF/ID update against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          N_CYCLES    = 3000;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_discards;
`endif

  if_fetch_unit #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (TB_RESET_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .branch_taken      (branch_taken),
    .branch_address    (branch_address),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched      (perf_fetched),
    .perf_bubbles      (perf_bubbles),
    .perf_discards     (perf_discards),
`endif
    .if_id_valid       (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb_q[$];

  // memory-side bookkeeping owned by the driver
  logic        mem_pending;
  int          mem_lat;
  logic [31:0] mem_addr;
  logic        tb_resp_real;

  // reference model state
  logic [31:0] exp_fetch;
  logic        req_open;
  logic        req_branched;
  logic [31:0] req_addr;
  logic        m_seen   = 1'b0;
  logic        m_rst    = 1'b0;
  logic        m_upd    = 1'b0;
  logic        m_branch = 1'b0;
  int          n_delivered = 0;
  int          n_bubbles   = 0;
  int          n_discards  = 0;

  // -------------------------------------------------------------------------
  // Reference model: samples each cycle mid-period, decides which responses
  // survive and what IF/ID must show after the coming edge.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    m_seen = 1'b1;
    if (rst) begin
      sb_q.delete();
      exp_fetch    = TB_RESET_PC;
      req_open     = 1'b0;
      req_branched = 1'b0;
      n_delivered  = 0;
      n_bubbles    = 0;
      n_discards   = 0;
      m_rst        = 1'b1;
      m_upd        = 1'b0;
      m_branch     = 1'b0;
    end else begin
      m_rst = 1'b0;
      if (imem_req && imem_ready) begin
        if (!branch_taken) chk("fetch_addr", imem_addr, exp_fetch);
        req_open     = 1'b1;
        req_addr     = imem_addr;
        req_branched = branch_taken;
      end else if (req_open && branch_taken) begin
        req_branched = 1'b1;
      end
      if (tb_resp_real) begin
        req_open = 1'b0;
        if (req_branched || branch_taken) begin
          n_discards++;
        end else begin
          sb_q.push_back('{pc: req_addr + 32'd4, instr: mem_word(req_addr)});
          exp_fetch = req_addr + 32'd4;
        end
      end
      if (branch_taken) begin
        sb_q.delete();
        exp_fetch = {branch_address[31:2], 2'b00};
      end
      m_branch = branch_taken;
      m_upd    = branch_taken || !freeze;
      if (m_upd) begin
        if (!branch_taken && sb_q.size() > 0) n_delivered++;
        else n_bubbles++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: checks IF/ID after every edge against the model's decision.
  // -------------------------------------------------------------------------
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        prev_valid;

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (m_seen) begin
      if (m_rst) begin
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_if_id_instr", if_id_instruction, 32'd0);
        chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
        chk("rst_imem_addr", imem_addr, TB_RESET_PC);
      end else if (m_upd) begin
        if (!m_branch && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("deliver_valid", {31'd0, if_id_valid}, 32'd1);
          chk("deliver_pc", if_id_pc, e.pc);
          chk("deliver_instr", if_id_instruction, e.instr);
        end else begin
          chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
          chk("bubble_instr", if_id_instruction, 32'd0);
          chk("bubble_pc_hold", if_id_pc, prev_pc);
        end
      end else begin
        chk("freeze_pc_hold", if_id_pc, prev_pc);
        chk("freeze_instr_hold", if_id_instruction, prev_instr);
        chk("freeze_valid_hold", {31'd0, if_id_valid}, {31'd0, prev_valid});
      end
      prev_pc    = if_id_pc;
      prev_instr = if_id_instruction;
      prev_valid = if_id_valid;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus + memory model
  // -------------------------------------------------------------------------
  int frz_cnt = 0;

  task automatic drive_cycle(input int cyc);
    int phase;
    int p_ready;
    int p_freeze;
    int p_branch;
    logic zero_lat;
    phase    = (cyc / 500) % 3;
    zero_lat = (phase == 0);
    p_ready  = (phase == 0) ? 100 : 65;
    p_freeze = (phase == 0) ? 5 : ((phase == 1) ? 15 : 30);
    p_branch = (phase == 0) ? 2 : ((phase == 1) ? 6 : 15);

    rst = (cyc == 1500 || cyc == 1501);
    tb_resp_real = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    if (rst) begin
      mem_pending    = 1'b0;
      imem_ready     = 1'b0;
      freeze         = 1'b0;
      branch_taken   = 1'b0;
      frz_cnt        = 0;
      return;
    end

    if (mem_pending && mem_lat == 0) begin
      imem_rvalid  = 1'b1;
      imem_rdata   = mem_word(mem_addr);
      tb_resp_real = 1'b1;
      mem_pending  = 1'b0;
    end else if (mem_pending) begin
      mem_lat--;
    end else if ($urandom_range(99) < 4) begin
      // stray response outside WAIT must be ignored
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end

    if (frz_cnt > 0) begin
      frz_cnt--;
      freeze = 1'b1;
    end else if ($urandom_range(99) < p_freeze) begin
      frz_cnt = $urandom_range(0, 4);
      freeze  = 1'b1;
    end else begin
      freeze = 1'b0;
    end

    branch_taken   = ($urandom_range(99) < p_branch);
    branch_address = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                                              : 32'($urandom);

    imem_ready = ($urandom_range(99) < p_ready);
    if (imem_req && imem_ready) begin
      mem_pending = 1'b1;
      mem_addr    = imem_addr;
      mem_lat     = zero_lat ? 0 : $urandom_range(0, 3);
    end
  endtask

  initial begin
    rst            = 1'b1;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_address = '0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    tb_resp_real   = 1'b0;
    mem_pending    = 1'b0;
    mem_lat        = 0;
    mem_addr       = '0;
    repeat (3) @(posedge clk);
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      drive_cycle(cyc);
    end
    @(posedge clk);
    #3;
    chk("progress", {31'd0, (n_delivered > 200)}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(n_delivered));
    chk("perf_bubbles", perf_bubbles, 32'(n_bubbles));
    chk("perf_discards", perf_discards, 32'(n_discards));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
